// File: rtl/nn_frame_streamer_if.sv
// Host/stream bundle for nn_frame_streamer: buffer write port, run control and pixel beat outputs.
interface nn_frame_streamer_if #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned PIX_W = 9
);
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int unsigned XW     = $clog2(IMG_W);
    localparam int unsigned YW     = $clog2(IMG_H);

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic signed [PIX_W-1:0] wr_data;
    logic                    wr_reject;
    logic                    start;
    logic [7:0]              n_frames;
    logic                    pause;
    logic                    abort;
    logic                    out_valid;
    logic signed [PIX_W-1:0] out_pixel;
    logic [XW-1:0]           out_x;
    logic [YW-1:0]           out_y;
    logic                    sof;
    logic                    eol;
    logic                    eof;
    logic                    busy;
    logic                    done;

    modport master (
        output wr_en, wr_addr, wr_data, start, n_frames, pause, abort,
        input  wr_reject, out_valid, out_pixel, out_x, out_y, sof, eol, eof, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, n_frames, pause, abort,
        output wr_reject, out_valid, out_pixel, out_x, out_y, sof, eol, eof, busy, done
    );
endinterface

// File: rtl/nn_frame_streamer.sv
// Frame buffer plus raster replay engine: streams IMG_W x IMG_H pixels one per cycle
// with optional line/frame gaps, pause, abort and multi-frame repeat.
module nn_frame_streamer #(
    parameter int unsigned IMG_W     = 8,
    parameter int unsigned IMG_H     = 8,
    parameter int unsigned PIX_W     = 9,
    parameter int unsigned LINE_GAP  = 0,
    parameter int unsigned FRAME_GAP = 4,
    parameter int unsigned ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    nn_frame_streamer_if.slave bus
);
    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned XW      = $clog2(IMG_W);
    localparam int unsigned YW      = $clog2(IMG_H);
    localparam int unsigned GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int unsigned GW      = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_LGAP, S_FGAP, S_DONE} state_t;

    state_t                  state_q, state_nxt;
    logic [XW-1:0]           x_q, x_nxt;
    logic [YW-1:0]           y_q, y_nxt;
    logic [ADDR_W-1:0]       addr_q, addr_nxt;
    logic [GW-1:0]           gap_q, gap_nxt;
    logic [7:0]              frames_q, frames_nxt;
    logic                    cont_q, cont_nxt;

    logic                    valid_q, valid_nxt;
    logic signed [PIX_W-1:0] pixel_q, pixel_nxt;
    logic [XW-1:0]           ox_q, ox_nxt;
    logic [YW-1:0]           oy_q, oy_nxt;
    logic                    sof_q, sof_nxt;
    logic                    eol_q, eol_nxt;
    logic                    eof_q, eof_nxt;
    logic                    busy_q, busy_nxt;
    logic                    done_q, done_nxt;
    logic                    reject_q, reject_nxt;

    logic signed [PIX_W-1:0] mem [NPIX];
    logic signed [PIX_W-1:0] rd_pixel;
    logic                    last_col, last_row, more;

    // Buffer: writable only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_q && (32'(bus.wr_addr) < NPIX))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign rd_pixel = mem[addr_q];
    assign last_col = (x_q == XW'(IMG_W - 1));
    assign last_row = (y_q == YW'(IMG_H - 1));
    assign more     = cont_q || (frames_q > 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            gap_q    <= '0;
            frames_q <= '0;
            cont_q   <= 1'b0;
            valid_q  <= 1'b0;
            pixel_q  <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            addr_q   <= addr_nxt;
            gap_q    <= gap_nxt;
            frames_q <= frames_nxt;
            cont_q   <= cont_nxt;
            valid_q  <= valid_nxt;
            pixel_q  <= pixel_nxt;
            ox_q     <= ox_nxt;
            oy_q     <= oy_nxt;
            sof_q    <= sof_nxt;
            eol_q    <= eol_nxt;
            eof_q    <= eof_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            reject_q <= reject_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        x_nxt      = x_q;
        y_nxt      = y_q;
        addr_nxt   = addr_q;
        gap_nxt    = gap_q;
        frames_nxt = frames_q;
        cont_nxt   = cont_q;
        valid_nxt  = 1'b0;
        pixel_nxt  = pixel_q;
        ox_nxt     = ox_q;
        oy_nxt     = oy_q;
        sof_nxt    = 1'b0;
        eol_nxt    = 1'b0;
        eof_nxt    = 1'b0;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        reject_nxt = bus.wr_en && busy_q;

        if (state_q != S_IDLE && bus.abort) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nxt  = S_STREAM;
                        busy_nxt   = 1'b1;
                        x_nxt      = '0;
                        y_nxt      = '0;
                        addr_nxt   = '0;
                        frames_nxt = bus.n_frames;
                        cont_nxt   = (bus.n_frames == 8'd0);
                    end
                end
                S_STREAM: begin
                    // Issue the pixel at the held position, then advance raster
                    if (!bus.pause) begin
                        valid_nxt = 1'b1;
                        pixel_nxt = rd_pixel;
                        ox_nxt    = x_q;
                        oy_nxt    = y_q;
                        sof_nxt   = (x_q == '0) && (y_q == '0);
                        eol_nxt   = last_col;
                        eof_nxt   = last_col && last_row;
                        if (!last_col) begin
                            x_nxt    = x_q + XW'(1);
                            addr_nxt = addr_q + ADDR_W'(1);
                        end else if (!last_row) begin
                            x_nxt    = '0;
                            y_nxt    = y_q + YW'(1);
                            addr_nxt = addr_q + ADDR_W'(1);
                            if (LINE_GAP > 0) begin
                                state_nxt = S_LGAP;
                                gap_nxt   = GW'(LINE_GAP - 1);
                            end
                        end else begin
                            x_nxt    = '0;
                            y_nxt    = '0;
                            addr_nxt = '0;
                            if (more) begin
                                if (!cont_q) frames_nxt = frames_q - 8'd1;
                                if (FRAME_GAP > 0) begin
                                    state_nxt = S_FGAP;
                                    gap_nxt   = GW'(FRAME_GAP - 1);
                                end
                            end else begin
                                state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_LGAP, S_FGAP: begin
                    if (gap_q == '0) state_nxt = S_STREAM;
                    else             gap_nxt   = gap_q - GW'(1);
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_pixel = pixel_q;
    assign bus.out_x     = ox_q;
    assign bus.out_y     = oy_q;
    assign bus.sof       = sof_q;
    assign bus.eol       = eol_q;
    assign bus.eof       = eof_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_reject = reject_q;
endmodule

// File: tb/tb_nn_frame_streamer.sv
// Directed bench for nn_frame_streamer: 8x8 frame, one instance with no line gap, one with LINE_GAP=2.
module tb_nn_frame_streamer;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, start1, pause, abort, wr_en;
    logic [5:0]        wr_addr;
    logic signed [8:0] wr_data;
    logic [7:0]        n_frames;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    nn_frame_streamer_if #(.IMG_W(8), .IMG_H(8), .PIX_W(9)) if0 ();
    nn_frame_streamer_if #(.IMG_W(8), .IMG_H(8), .PIX_W(9)) if1 ();

    assign if0.wr_en = wr_en;    assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
    assign if0.n_frames = n_frames; assign if1.n_frames = n_frames;
    assign if0.pause = pause;    assign if1.pause = pause;
    assign if0.abort = abort;    assign if1.abort = abort;
    assign if0.start = start;    assign if1.start = start1;

    nn_frame_streamer #(.IMG_W(8), .IMG_H(8), .PIX_W(9), .LINE_GAP(0), .FRAME_GAP(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    nn_frame_streamer #(.IMG_W(8), .IMG_H(8), .PIX_W(9), .LINE_GAP(2), .FRAME_GAP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        bit       start;
        bit [7:0] nf;
        bit       valid;
        int       pixel;
        int       x;
        int       y;
        bit       sof, eol, eof, busy, done;
    } vec_t;
    vec_t vt[67];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Single run on dut0 with optional pause / abort / reset / busy-write injection points
    task automatic run0(input int nf, input int pause_at, input int abort_at, input int rst_at,
                        input int wr_at, input int exp_first,
                        output int beats, output int idles, output int sofs,
                        output int dones, output int rejects);
        int pend, pcnt, pos;
        bit fin;
        beats = 0; idles = 0; sofs = 0; dones = 0; rejects = 0;
        pend = 0; pcnt = 0; fin = 1'b0;
        n_frames = 8'(nf); start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            step();
            if (if0.wr_reject) rejects++;
            if (if0.done) begin dones++; fin = 1'b1; end
            if (if0.out_valid) begin
                beats++; idles += pend; pend = 0; pos = (beats - 1) % 64;
                chk("pixel", int'(if0.out_pixel), (pos == 0) ? exp_first : pos + 1);
                chk("x", int'(if0.out_x), pos % 8);
                chk("y", int'(if0.out_y), pos / 8);
                chk("sof", int'(if0.sof), int'(pos == 0));
                chk("eol", int'(if0.eol), int'(pos % 8 == 7));
                chk("eof", int'(if0.eof), int'(pos == 63));
                if (pos == 0) sofs++;
            end else if (beats > 0) begin
                pend++;
            end
            pause = (beats == pause_at) && (pcnt < 3);
            if (pause) pcnt++;
            wr_en = (beats == wr_at) && if0.out_valid;
            wr_addr = 6'd0; wr_data = -9'sd5;
            if (beats == abort_at && if0.out_valid) begin
                abort = 1'b1;
                step();
                abort = 1'b0; wr_en = 1'b0;
                chk("abort_valid", int'(if0.out_valid), 0);
                chk("abort_busy", int'(if0.busy), 0);
                repeat (3) begin
                    step();
                    chk("abort_quiet", int'(if0.out_valid | if0.done | if0.busy), 0);
                end
                fin = 1'b1;
            end
            if (beats == rst_at && if0.out_valid) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_async_valid", int'(if0.out_valid), 0);
                chk("rst_async_busy", int'(if0.busy), 0);
                step();
                rst_n = 1'b1;
                step();
                chk("rst_idle", int'(if0.out_valid | if0.busy | if0.done), 0);
                fin = 1'b1;
            end
        end
        pause = 1'b0; wr_en = 1'b0;
        if (!fin) chk("run0_timeout", 0, 1);
    endtask

    initial begin
        int beats, idles, sofs, dones, rejects, first_c, last_c, pend;
        bit fin;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; pause = 1'b0; abort = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; n_frames = 8'd1;

        vt[0] = '{start: 1'b1, nf: 8'd1, valid: 1'b0, pixel: 0, x: 0, y: 0,
                  sof: 1'b0, eol: 1'b0, eof: 1'b0, busy: 1'b1, done: 1'b0};
        for (int i = 1; i <= 64; i++)
            vt[i] = '{start: 1'b0, nf: 8'd1, valid: 1'b1, pixel: i, x: (i - 1) % 8, y: (i - 1) / 8,
                      sof: (i == 1), eol: (i % 8 == 0), eof: (i == 64), busy: 1'b1, done: 1'b0};
        vt[65] = '{start: 1'b0, nf: 8'd1, valid: 1'b0, pixel: 0, x: 0, y: 0,
                   sof: 1'b0, eol: 1'b0, eof: 1'b0, busy: 1'b0, done: 1'b1};
        vt[66] = '{start: 1'b0, nf: 8'd1, valid: 1'b0, pixel: 0, x: 0, y: 0,
                   sof: 1'b0, eol: 1'b0, eof: 1'b0, busy: 1'b0, done: 1'b0};

        step(); step();
        chk("reset_valid", int'(if0.out_valid), 0);
        chk("reset_busy", int'(if0.busy), 0);
        chk("reset_pixel", int'(if0.out_pixel), 0);
        chk("reset_done", int'(if0.done), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 9'(i + 1);
            step();
            chk("load_reject", int'(if0.wr_reject), 0);
        end
        wr_en = 1'b0;

        // T1: single frame, table of per-cycle expectations
        for (int i = 0; i < 67; i++) begin
            start = vt[i].start; n_frames = vt[i].nf;
            step();
            start = 1'b0;
            chk($sformatf("t1_valid[%0d]", i), int'(if0.out_valid), int'(vt[i].valid));
            chk($sformatf("t1_busy[%0d]", i), int'(if0.busy), int'(vt[i].busy));
            chk($sformatf("t1_done[%0d]", i), int'(if0.done), int'(vt[i].done));
            chk($sformatf("t1_flags[%0d]", i), int'({if0.sof, if0.eol, if0.eof}),
                int'({vt[i].sof, vt[i].eol, vt[i].eof}));
            if (vt[i].valid) begin
                chk($sformatf("t1_pixel[%0d]", i), int'(if0.out_pixel), vt[i].pixel);
                chk($sformatf("t1_xy[%0d]", i), int'(if0.out_y) * 8 + int'(if0.out_x),
                    vt[i].y * 8 + vt[i].x);
            end
        end

        // T2: LINE_GAP=2 instance
        beats = 0; pend = 0; first_c = 0; last_c = 0; fin = 1'b0; dones = 0;
        n_frames = 8'd1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            step();
            if (if1.done) begin dones++; fin = 1'b1; end
            if (if1.out_valid) begin
                beats++;
                if (beats == 1) first_c = c;
                last_c = c;
                chk("t2_pixel", int'(if1.out_pixel), beats);
                if (beats > 1) chk("t2_gap", pend, ((beats - 1) % 8 == 0) ? 2 : 0);
                pend = 0;
            end else if (beats > 0) begin
                pend++;
            end
        end
        chk("t2_beats", beats, 64);
        chk("t2_span", last_c - first_c + 1, 78);
        chk("t2_done", dones, 1);

        // T3: pause 3 cycles while beat 10 is next
        run0(1, 9, -1, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t3_beats", beats, 64);
        chk("t3_idles", idles, 3);
        chk("t3_done", dones, 1);

        // T4: two frames with FRAME_GAP=4
        run0(2, -1, -1, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t4_beats", beats, 128);
        chk("t4_sofs", sofs, 2);
        chk("t4_idles", idles, 4);
        chk("t4_done", dones, 1);

        // T5: write while busy is rejected; idle write is accepted
        run0(1, -1, -1, -1, 20, 1, beats, idles, sofs, dones, rejects);
        chk("t5_rejects", rejects, 1);
        chk("t5_beats", beats, 64);
        run0(1, -1, -1, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t5_rerun_beats", beats, 64);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = -9'sd5;
        step();
        wr_en = 1'b0;
        chk("t5_idle_reject", int'(if0.wr_reject), 0);
        run0(1, -1, -1, -1, -1, -5, beats, idles, sofs, dones, rejects);
        chk("t5_neg_beats", beats, 64);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 9'sd1;
        step();
        wr_en = 1'b0;

        // T6: abort at beat 30, then reset at beat 30, each followed by a clean run
        run0(1, -1, 30, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t6_abort_beats", beats, 30);
        chk("t6_abort_done", dones, 0);
        run0(1, -1, -1, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t6_restart_beats", beats, 64);
        run0(1, -1, -1, 30, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t6_rst_beats", beats, 30);
        chk("t6_rst_done", dones, 0);
        run0(1, -1, -1, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("t6_rst_restart_beats", beats, 64);

        // Continuous mode stopped by abort
        run0(0, -1, 100, -1, -1, 1, beats, idles, sofs, dones, rejects);
        chk("cont_beats", beats, 100);
        chk("cont_sofs", sofs, 2);
        chk("cont_idles", idles, 4);
        chk("cont_done", dones, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
